// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// ALU function codes, MD op codes, FSM states and the 64-bit negate helper.
package md_sequencer_pkg;

  localparam logic [4:0] AluNop = 5'd0;
  localparam logic [4:0] AluAdd = 5'd1;
  localparam logic [4:0] AluSub = 5'd2;

  typedef enum logic [1:0] {
    OpMultu = 2'd0,
    OpMult  = 2'd1,
    OpDivu  = 2'd2,
    OpDiv   = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPrep = 2'd1,
    StRun  = 2'd2,
    StFix  = 2'd3
  } md_state_e;

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; drives an external ALU
// one shift-add / restoring-divide step per cycle.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned Iter = 32,
  parameter int unsigned CntW = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_ctrl,
  output logic        alu_sign,
  input  logic [31:0] alu_out
);

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  // a: P_hi / remainder, b: P_lo / quotient, m: multiplicand / divisor
  logic [31:0]     a_q, a_d, b_q, b_d, m_q, m_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d;

  logic            is_div, sa_new, sb_new, carry, qb;
  logic [31:0]     mag_s, mag_t, sh;
  logic [63:0]     prod;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    alu_in1  = 32'd0;
    alu_in2  = 32'd0;
    alu_ctrl = AluNop;

    is_div = op_q[1];
    sa_new = op_q[0] & b_q[31];
    sb_new = op_q[0] & m_q[31];
    mag_s  = sa_new ? -b_q : b_q;
    mag_t  = sb_new ? -m_q : m_q;
    sh     = {a_q[30:0], b_q[31]};
    carry  = 1'b0;
    qb     = 1'b0;
    prod   = {a_q, b_q};

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPrep;
          op_d    = md_op_e'(op);
          b_d     = rs;
          m_d     = rt;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      StPrep: begin
        sa_d    = sa_new;
        sb_d    = sb_new;
        a_d     = 32'd0;
        cnt_d   = '0;
        b_d     = is_div ? mag_s : mag_t;
        m_d     = is_div ? mag_t : mag_s;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(Iter - 1)) state_d = StFix;
        if (!is_div) begin
          alu_in1  = a_q;
          alu_in2  = m_q;
          alu_ctrl = AluAdd;
          carry    = alu_out < a_q;
          if (b_q[0]) {a_d, b_d} = {carry, alu_out, b_q[31:1]};
          else        {a_d, b_d} = {1'b0, a_q, b_q[31:1]};
        end else begin
          alu_in1  = sh;
          alu_in2  = m_q;
          alu_ctrl = AluSub;
          // R[31] set means the shifted remainder is >= 2^32, hence >= D
          qb       = a_q[31] | (sh >= m_q);
          a_d      = qb ? alu_out : sh;
          b_d      = {b_q[30:0], qb};
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (!is_div) begin
          if (sa_q ^ sb_q) prod = neg64({a_q, b_q});
          {hi_d, lo_d} = prod;
        end else begin
          lo_d = (sa_q ^ sb_q) ? -b_q : b_q;
          hi_d = sa_q ? -a_q : a_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpMultu;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      m_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign alu_sign = 1'b0;

endmodule
